// File: rtl/sw_cond_pkg.sv
// Shared constants and helpers for the slide-switch conditioning path.
package sw_cond_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int DEBOUNCE_MS = 1;

    // Number of clk cycles a new switch level must hold before it is accepted.
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Smallest counter width w such that 2^w > cycles.
    function automatic int min_cnt_w(input int cycles);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) <= cycles) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage : sw_cond_pkg

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, clean level flop
// and registered rise/fall pulses. The rise/fall event terms are also exported
// unregistered so the top can register their OR in the same cycle as the pulses.
module switch_debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic rise_evt,
    output logic fall_evt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;

    // Next-state: synchronise, count consecutive disagreeing cycles, accept at the limit.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        cnt_d   = '0;
        accept  = 1'b0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_MAX) begin
                // Level held long enough: take it and restart the counter.
                accept  = 1'b1;
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Any agreement between sync2 and clean leaves cnt_d at zero (glitch rejection).
        rise_d = accept & sync2_q;
        fall_d = accept & ~sync2_q;
    end

    // State registers; asynchronous active-low reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_clean   = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_evt   = rise_d;
    assign fall_evt   = fall_d;

endmodule : switch_debounce_bit

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw slide-switch pins into a clean level bus for the PIO,
// with per-bit one-cycle rise/fall pulses and a combined any_change flag.
// Pure streaming stage: no handshake, outputs are valid every cycle.
module switch_debouncer
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end
    if (CNT_W < min_cnt_w(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("switch_debouncer: CNT_W too small for DEBOUNCE_CYCLES");
    end

    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic             any_change_q, any_change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .sw_raw     (sw_raw[i]),
            .sw_clean   (sw_clean[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .rise_evt   (rise_evt[i]),
            .fall_evt   (fall_evt[i])
        );
    end

    // OR of all per-bit event terms, registered so it lines up with the pulses.
    always_comb begin
        any_change_d = |(rise_evt | fall_evt);
    end

    // any_change register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DEBOUNCE_CYCLES=8, CNT_W=4.
// Stimulus pushes expected events {cycle, rise, fall, sw_clean} into exp_q;
// the monitor pops and compares whenever the DUT shows a pulse or any_change.
module tb_switch_debouncer;

  localparam int W = 28;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       any_change;

  logic [15:0]  cyc;
  logic [W-1:0] exp_q[$];
  int           tests;
  int           failed;
  logic [15:0]  n;

  switch_debouncer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  function automatic logic [W-1:0] pack(input logic [15:0] c, input logic [3:0] r,
                                        input logic [3:0] f, input logic [3:0] cl);
    return {c, r, f, cl};
  endfunction

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {19'd0, sw_clean, rise_pulse, fall_pulse, any_change}, 32'd0);
  endtask

  // expected event helper: edge of change = drive cycle + 10
  task automatic expect_event(input logic [15:0] drive_cyc, input logic [3:0] r,
                              input logic [3:0] f, input logic [3:0] cl);
    exp_q.push_back(pack(drive_cyc + 16'd10, r, f, cl));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rise_pulse != 4'd0 || fall_pulse != 4'd0 || any_change) begin
      tests++;
      got = pack(cyc, rise_pulse, fall_pulse, sw_clean);
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_event cyc=%0d rise=%b fall=%b clean=%b any=%b",
                 cyc, rise_pulse, fall_pulse, sw_clean, any_change);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp || any_change !== 1'b1) begin
          failed++;
          $display("FAIL event got cyc=%0d rise=%b fall=%b clean=%b any=%b expected cyc=%0d rise=%b fall=%b clean=%b any=1",
                   got[27:12], got[11:8], got[7:4], got[3:0], any_change,
                   exp[27:12], exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    tests   = 0;
    failed  = 0;
    reset_n = 1'b0;
    sw_raw  = 4'b0000;

    // reset, then idle
    step(3);
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    step(50);
    check("idle_clean", {28'd0, sw_clean}, 32'd0);
    check("idle_any", {31'd0, any_change}, 32'd0);

    // single bit rise
    sw_raw = 4'b0001;
    n = cyc;
    expect_event(n, 4'b0001, 4'b0000, 4'b0001);
    step(9);
    check("bit0_before_latency", {28'd0, sw_clean}, 32'h0);
    step(1);
    check("bit0_after_latency", {28'd0, sw_clean}, 32'h1);
    step(5);

    // bounce train on bit 2
    sw_raw[2] = 1'b1; step(3);
    sw_raw[2] = 1'b0; step(3);
    sw_raw[2] = 1'b1; step(3);
    sw_raw[2] = 1'b0; step(3);
    check("bit2_bouncing", {28'd0, sw_clean}, 32'h1);
    sw_raw[2] = 1'b1;
    n = cyc;
    expect_event(n, 4'b0100, 4'b0000, 4'b0101);
    step(9);
    check("bit2_before_latency", {28'd0, sw_clean}, 32'h1);
    step(1);
    check("bit2_after_latency", {28'd0, sw_clean}, 32'h5);
    step(5);

    // multi-bit simultaneous changes
    sw_raw = 4'b0000;
    n = cyc;
    expect_event(n, 4'b0000, 4'b0101, 4'b0000);
    step(15);
    sw_raw = 4'b1010;
    n = cyc;
    expect_event(n, 4'b1010, 4'b0000, 4'b1010);
    step(15);
    check("multi_rise_clean", {28'd0, sw_clean}, 32'ha);
    sw_raw = 4'b0000;
    n = cyc;
    expect_event(n, 4'b0000, 4'b1010, 4'b0000);
    step(15);
    check("multi_fall_clean", {28'd0, sw_clean}, 32'h0);

    // reset with a partial count on bit 1 (count reaches 5 seven edges after drive)
    sw_raw = 4'b0010;
    step(7);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset_immediate");
    step(3);
    check_all_zero("midreset_hold");
    reset_n = 1'b1;
    n = cyc;
    expect_event(n, 4'b0010, 4'b0000, 4'b0010);
    step(9);
    check("requal_before_latency", {28'd0, sw_clean}, 32'h0);
    step(1);
    check("requal_after_latency", {28'd0, sw_clean}, 32'h2);
    step(5);

    // single-cycle glitches on bit 3
    for (int i = 0; i < 5; i++) begin
      sw_raw[3] = 1'b1;
      step(1);
      sw_raw[3] = 1'b0;
      step(9);
    end
    step(10);
    check("glitch_clean", {28'd0, sw_clean}, 32'h2);

    // every expected event must have been seen
    check("events_outstanding", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_switch_debouncer
